bp_be_dcache_trace_driver: RTL
==============================

BP_BE_DCACHE_TRACE_DRIVER -- requirements
Module: bp_be_dcache_trace_driver

Interface
REQ-001 SHALL have parameter page_offset_width_p, default 12: dcache packet page-offset width.
REQ-002 SHALL have parameter ptag_width_p, default 28: physical tag width.
REQ-003 SHALL have parameter dword_width_p, default 64: load data width.
REQ-004 SHALL have parameter dcache_pkt_width_p, default bp_be_dcache_pkt_width(page_offset_width_p, dword_width_p): packet width.
REQ-005 SHALL have parameter rom_addr_width_p, default 10: trace ROM address width.
REQ-006 SHALL have parameter max_outstanding_p, default 8: scoreboard depth; power of two, at least 2.
REQ-007 SHALL have parameter timeout_p, default 1024: watchdog limit in cycles.
REQ-008 clk_i  in  1  single clock, rising edge.
REQ-009 reset_n_i  in  1  asynchronous, active-low reset.
REQ-010 rom_addr_o  out  rom_addr_width_p  trace entry index (pc).
REQ-011 rom_data_i  in  E = 2+dcache_pkt_width_p+ptag_width_p+dword_width_p  entry {op[1:0], pkt, ptag, exp_data}, valid in the same cycle as rom_addr_o.
REQ-012 dcache_pkt_o  out  dcache_pkt_width_p  packet to the rolly fifo.
REQ-013 ptag_o  out  ptag_width_p  physical tag paired with the packet.
REQ-014 v_o / ready_i  out / in  1 each  valid-ready request handshake.
REQ-015 v_i / data_i  in  1 / dword_width_p  dcache response; no backpressure.
REQ-016 done_o, error_o, timeout_o  out  1 each  sticky status flags.
REQ-017 mismatch_count_o  out  16  count of failed data checks.

Function
REQ-018 Op encoding SHALL be: 00 REQ (send, no check), 01 REQ_CHK (send, compare data), 10 WAIT, 11 END.
REQ-019 FSM SHALL have exactly three states: e_run, e_drain, e_done.
REQ-020 In e_run with op REQ or REQ_CHK, v_o SHALL equal (outstanding < max_outstanding_p), driven combinationally from rom_data_i.
REQ-021 On v_o & ready_i, pc SHALL increment at the same edge. {check bit, exp_data} SHALL be pushed to the in-order scoreboard FIFO at that edge and outstanding SHALL increment.
REQ-022 On v_i, the scoreboard head SHALL be popped. If the head check bit is 1 and data_i != exp_data, error_o and mismatch_count_o++ SHALL take effect at the next edge.
REQ-023 Push and pop in the same cycle SHALL leave outstanding unchanged. Full and empty are both legal.
REQ-024 v_i while outstanding==0 SHALL set error_o; no pop occurs and the count is unchanged.
REQ-025 WAIT SHALL hold pc and keep v_o=0 until outstanding==0 at the start of a cycle, then pc SHALL increment.
REQ-026 END SHALL move the FSM to e_drain with v_o=0.
REQ-027 Accepting the entry at pc = 2^rom_addr_width_p-1 SHALL also move the FSM to e_drain; pc SHALL never wrap.
REQ-028 e_drain SHALL go to e_done when outstanding==0. In e_done, done_o=1, v_o=0, and the FSM SHALL remain there until reset.
REQ-029 mismatch_count_o SHALL saturate at 16'hFFFF.
REQ-030 Request latency SHALL be zero cycles from entry presentation to v_o, and there SHALL be no bubble between consecutive accepted REQs.

Reset
REQ-031 reset_n_i low SHALL asynchronously clear: pc=0, state=e_run, outstanding=0, scoreboard pointers=0, done_o=0, error_o=0, timeout_o=0, mismatch_count_o=0, watchdog=0.
REQ-032 During reset, v_o SHALL be 0. Deassertion SHALL be synchronized externally; reset mid-run SHALL discard all outstanding entries.

Configuration
REQ-033 With BP_BE_TRACE_DRIVER_TIMEOUT_EN defined: the watchdog SHALL count cycles with outstanding>0 and no v_i, and clear on v_i or when outstanding==0. On reaching timeout_p it SHALL set timeout_o and error_o and force e_done.
REQ-034 Without BP_BE_TRACE_DRIVER_TIMEOUT_EN: there SHALL be no watchdog logic, timeout_o SHALL be tied to 0, and timeout_p SHALL be unused.

Verification
REQ-035 3 REQ_CHK loads then END, ready_i=1, responses one cycle after each accept with matching data -> v_o high 3 consecutive cycles, done_o=1, error_o=0, count=0.
REQ-036 max_outstanding_p=8, 10 REQs, no responses -> exactly 8 accepts, v_o=0 thereafter. One response -> 9th accept on the next cycle.
REQ-037 REQ_CHK exp=64'hDEAD_BEEF, response 64'h0 -> error_o=1, mismatch_count_o=1, done_o still asserts after drain.
REQ-038 REQ, WAIT, REQ with response delayed 20 cycles -> second v_o asserts only in the cycle after outstanding reaches 0.
REQ-039 v_i pulse with empty scoreboard -> error_o=1, count=0. Reset asserted mid-run with 4 outstanding -> all outputs 0 immediately, restart from pc=0.
REQ-040 With TIMEOUT_EN, timeout_p=16, one REQ never answered -> timeout_o=error_o=done_o=1 sixteen cycles after accept. Without it -> the FSM stays in e_run/e_drain.

Source files
------------

// File: rtl/bp_be_dcache_trace_driver.sv
// Trace-ROM driven dcache exerciser: issues packets and checks load data in order.
// Defining BP_BE_TRACE_DRIVER_TIMEOUT_EN adds a response watchdog.
module bp_be_dcache_trace_driver #(
    parameter int page_offset_width_p = 12,
    parameter int ptag_width_p        = 28,
    parameter int dword_width_p       = 64,
    // bp_be_dcache_pkt_width: rd_addr(5) + opcode(5) + page offset + data
    parameter int dcache_pkt_width_p  = 5 + 5 + page_offset_width_p + dword_width_p,
    parameter int rom_addr_width_p    = 10,
    parameter int max_outstanding_p   = 8,
    parameter int timeout_p           = 1024,
    localparam int entry_width_lp     = 2 + dcache_pkt_width_p + ptag_width_p + dword_width_p
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    output logic [rom_addr_width_p-1:0]   rom_addr_o,
    input  logic [entry_width_lp-1:0]     rom_data_i,
    output logic [dcache_pkt_width_p-1:0] dcache_pkt_o,
    output logic [ptag_width_p-1:0]       ptag_o,
    output logic                          v_o,
    input  logic                          ready_i,
    input  logic                          v_i,
    input  logic [dword_width_p-1:0]      data_i,
    output logic                          done_o,
    output logic                          error_o,
    output logic                          timeout_o,
    output logic [15:0]                   mismatch_count_o,
    output logic [1:0]                    state_o
);

    typedef enum logic [1:0] {e_run = 2'd0, e_drain = 2'd1, e_done = 2'd2} state_e;

    localparam logic [1:0] op_wait_lp = 2'b10;
    localparam logic [1:0] op_end_lp  = 2'b11;
    localparam int ptr_w_lp = $clog2(max_outstanding_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam logic [cnt_w_lp-1:0] max_out_lp = cnt_w_lp'(max_outstanding_p);
    localparam logic [rom_addr_width_p-1:0] last_pc_lp = '1;

    state_e                      state_q;
    logic [rom_addr_width_p-1:0] pc_q;
    logic [cnt_w_lp-1:0]         outstanding_q, outstanding_d;
    logic [ptr_w_lp-1:0]         wr_ptr_q, rd_ptr_q;
    logic                        done_q, error_q;
    logic [15:0]                 mismatch_q;
    logic [max_outstanding_p-1:0] sb_chk_q;
    logic [dword_width_p-1:0]    sb_data_q [max_outstanding_p];

    logic [1:0]               op;
    logic [dword_width_p-1:0] exp_data;
    logic                     push, pop, mismatch, advance, wd_fire;

    assign op       = rom_data_i[entry_width_lp-1 -: 2];
    assign exp_data = rom_data_i[dword_width_p-1:0];

    // Request handshake: a transfer happens on any cycle with v_o & ready_i high.
    // v_o never depends on ready_i and is forced low while reset is asserted.
    assign v_o  = reset_n_i && (state_q == e_run) && !op[1] && (outstanding_q < max_out_lp);
    assign push = v_o & ready_i;
    assign pop  = v_i & (outstanding_q != '0);
    assign mismatch = pop & sb_chk_q[rd_ptr_q] & (data_i != sb_data_q[rd_ptr_q]);
    assign advance  = push | ((state_q == e_run) && (op == op_wait_lp) && (outstanding_q == '0));
    assign outstanding_d = outstanding_q + cnt_w_lp'(push) - cnt_w_lp'(pop);

    assign rom_addr_o       = pc_q;
    assign dcache_pkt_o     = v_o ? rom_data_i[entry_width_lp-3 -: dcache_pkt_width_p] : '0;
    assign ptag_o           = v_o ? rom_data_i[dword_width_p +: ptag_width_p] : '0;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign mismatch_count_o = mismatch_q;
    assign state_o          = state_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            sb_chk_q[wr_ptr_q]  <= op[0];
            sb_data_q[wr_ptr_q] <= exp_data;
        end
    end

`ifdef BP_BE_TRACE_DRIVER_TIMEOUT_EN
    localparam int wd_w_lp = $clog2(timeout_p + 1);
    localparam logic [wd_w_lp-1:0] wd_last_lp = wd_w_lp'(timeout_p - 1);
    logic [wd_w_lp-1:0] wd_q;
    logic               wd_idle;
    logic               timeout_q;

    assign wd_idle   = (outstanding_q == '0) || v_i || (state_q == e_done);
    assign wd_fire   = !wd_idle && (wd_q == wd_last_lp);
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= wd_idle ? '0 : wd_q + wd_w_lp'(1);
            if (wd_fire) timeout_q <= 1'b1;
        end
    end
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= e_run;
            pc_q          <= '0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            mismatch_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (push) wr_ptr_q <= wr_ptr_q + ptr_w_lp'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ptr_w_lp'(1);
            // A response with nothing outstanding is a protocol error, not a data check
            if ((v_i && (outstanding_q == '0)) || mismatch) error_q <= 1'b1;
            if (mismatch && (mismatch_q != 16'hFFFF)) mismatch_q <= mismatch_q + 16'd1;
            case (state_q)
                e_run: begin
                    if (advance) begin
                        if (pc_q == last_pc_lp) state_q <= e_drain;
                        else                    pc_q    <= pc_q + rom_addr_width_p'(1);
                    end else if (op == op_end_lp) begin
                        state_q <= e_drain;
                    end
                end
                e_drain: begin
                    if (outstanding_q == '0) begin
                        state_q <= e_done;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= e_done;
                    done_q  <= 1'b1;
                end
            endcase
            if (wd_fire) begin
                state_q <= e_done;
                done_q  <= 1'b1;
                error_q <= 1'b1;
            end
        end
    end

endmodule
